reg_read_port: RTL and testbench

REG_READ_PORT -- requirements
Module: reg_read_port

---
 rtl/reg_read_port_pkg.sv | 14 +
 rtl/reg_read_mux.sv | 29 ++
 rtl/reg_read_port.sv | 119 +++++++++++
 tb/tb_reg_read_port.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_read_port_pkg.sv
// rtl/reg_read_port_pkg.sv - shared sizes and occupancy state for the register read port
package reg_read_port_pkg;

    localparam int NREG   = 8;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/reg_read_mux.sv
// rtl/reg_read_mux.sv - one read source: register slice select with same-cycle write forwarding
module reg_read_mux
    import reg_read_port_pkg::*;
#(
    parameter int NREG  = reg_read_port_pkg::NREG,
    parameter int WIDTH = reg_read_port_pkg::WIDTH
) (
    input  logic [NREG*WIDTH-1:0] i_regs_flat,
    input  logic [ADDR_W-1:0]     i_sel,
    input  logic                  i_wr_n,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    output logic [WIDTH-1:0]      o_data
);

    always_comb begin
        o_data = '0;
        // Indices with no backing register fall through as zero.
        for (int i = 0; i < NREG; i++) begin
            if (int'(i_sel) == i) begin
                o_data = i_regs_flat[i*WIDTH +: WIDTH];
            end
        end
        if (!i_wr_n && (i_wr_addr == i_sel)) begin
            o_data = i_wr_data;
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - two-source register read port with 1-cycle latency and a one-entry skid buffer
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int NREG  = reg_read_port_pkg::NREG,
    parameter int WIDTH = reg_read_port_pkg::WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREG*WIDTH-1:0] regs_flat,
    input  logic                  wr_n,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data_a,
    output logic [WIDTH-1:0]      rd_data_b,
    input  logic                  rd_accept
);

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_out_a, r_out_b;
    logic [WIDTH-1:0] r_skid_a, r_skid_b;
    logic [WIDTH-1:0] w_src_a, w_src_b;
    logic             w_accept, w_take;
    logic             w_load_out, w_load_skid, w_skid_to_out;

    reg_read_mux #(.NREG(NREG), .WIDTH(WIDTH)) u_mux_a (
        .i_regs_flat (regs_flat),
        .i_sel       (rd_addr_a),
        .i_wr_n      (wr_n),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_data      (w_src_a)
    );

    reg_read_mux #(.NREG(NREG), .WIDTH(WIDTH)) u_mux_b (
        .i_regs_flat (regs_flat),
        .i_sel       (rd_addr_b),
        .i_wr_n      (wr_n),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_data      (w_src_b)
    );

    // Handshake flags depend only on registered state, never on rd_accept.
    assign rd_ready  = (r_state != TWO);
    assign rd_valid  = (r_state != EMPTY);
    assign rd_data_a = r_out_a;
    assign rd_data_b = r_out_b;
    assign w_accept  = rd_req & rd_ready;
    assign w_take    = rd_valid & rd_accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_load_out  = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_take) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_take) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_take) begin
                    w_state_nxt   = ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_a  <= '0;
            r_out_b  <= '0;
            r_skid_a <= '0;
            r_skid_b <= '0;
        end else begin
            if (w_load_out) begin
                r_out_a <= w_src_a;
                r_out_b <= w_src_b;
            end else if (w_skid_to_out) begin
                r_out_a <= r_skid_a;
                r_out_b <= r_skid_b;
            end
            if (w_load_skid) begin
                r_skid_a <= w_src_a;
                r_skid_b <= w_src_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// tb/tb_reg_read_port.sv - directed vector table plus queue-model random checks for reg_read_port
module tb_reg_read_port;

    localparam int NREG  = 8;
    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              reset, wr_n, rd_req, rd_accept, rd_ready, rd_valid;
    logic [2:0]        wr_addr, rd_addr_a, rd_addr_b;
    logic [WIDTH-1:0]  wr_data, rd_data_a, rd_data_b;
    logic [NREG*WIDTH-1:0] regs_flat;
    logic [WIDTH-1:0]  rf [NREG];

    int          total = 0;
    int          bad = 0;
    int          n_acc = 0;
    int          n_take = 0;
    logic [31:0] q [$];

    always #5 clk = ~clk;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG; i++) regs_flat[i*WIDTH +: WIDTH] = rf[i];
    end

    reg_read_port #(.NREG(NREG), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .regs_flat (regs_flat),
        .wr_n      (wr_n),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_accept (rd_accept)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] src(input logic [2:0] idx, input logic wrn,
                                        input logic [2:0] wa, input logic [15:0] wd);
        if (!wrn && wa == idx) return wd;
        if (int'(idx) < NREG) return rf[idx];
        return 16'h0;
    endfunction

    // One clock of stimulus; the model is a FIFO of at most two pending results.
    task automatic step(input logic rst_n, input logic req, input logic [2:0] a, input logic [2:0] b,
                        input logic acc, input logic wrn, input logic [2:0] wa, input logic [15:0] wd);
        logic [31:0] v;
        bit          accept, take;
        reset = rst_n; rd_req = req; rd_addr_a = a; rd_addr_b = b;
        rd_accept = acc; wr_n = wrn; wr_addr = wa; wr_data = wd;
        v      = {src(a, wrn, wa, wd), src(b, wrn, wa, wd)};
        take   = (q.size() > 0) && acc;
        accept = req && (q.size() < 2);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            if (take) begin
                void'(q.pop_front());
                n_take++;
            end
            if (accept) begin
                q.push_back(v);
                n_acc++;
            end
        end
        if (!wrn) rf[wa] = wd;
        #1;
        chk("model_valid", {31'b0, rd_valid}, {31'b0, q.size() > 0});
        chk("model_ready", {31'b0, rd_ready}, {31'b0, q.size() < 2});
        if (!rst_n) chk("model_rst_data", {rd_data_a, rd_data_b}, 32'h0);
        else if (q.size() > 0) chk("model_data", {rd_data_a, rd_data_b}, q[0]);
    endtask

    typedef struct {
        logic        rst_n, req;
        logic [2:0]  a, b;
        logic        acc, wrn;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ev, er, cd;
        logic [15:0] ea, eb;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic req, input logic [2:0] a, input logic [2:0] b,
                                input logic acc, input logic wrn, input logic [2:0] wa, input logic [15:0] wd,
                                input logic ev, input logic er, input logic cd,
                                input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.a = a; v.b = b; v.acc = acc; v.wrn = wrn;
        v.wa = wa; v.wd = wd; v.ev = ev; v.er = er; v.cd = cd; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < NREG; i++) rf[i] = 16'h0;
        rf[1] = 16'h1111; rf[3] = 16'h1234; rf[4] = 16'h4444; rf[5] = 16'hBEEF; rf[6] = 16'h0001;

        tbl[0]  = mk(1, 1, 3, 5, 1, 1, 0, 0,        1, 1, 1, 16'h1234, 16'hBEEF);
        tbl[1]  = mk(1, 0, 0, 0, 1, 1, 0, 0,        0, 1, 0, 16'h0,    16'h0);
        tbl[2]  = mk(1, 1, 2, 2, 0, 0, 2, 16'hA5A5, 1, 1, 1, 16'hA5A5, 16'hA5A5);
        tbl[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0,        0, 1, 0, 16'h0,    16'h0);
        tbl[4]  = mk(1, 1, 1, 1, 0, 1, 0, 0,        1, 1, 1, 16'h1111, 16'h1111);
        tbl[5]  = mk(1, 1, 4, 4, 0, 1, 0, 0,        1, 0, 1, 16'h1111, 16'h1111);
        tbl[6]  = mk(1, 1, 2, 2, 0, 1, 0, 0,        1, 0, 1, 16'h1111, 16'h1111);
        tbl[7]  = mk(1, 0, 0, 0, 1, 1, 0, 0,        1, 1, 1, 16'h4444, 16'h4444);
        tbl[8]  = mk(1, 0, 0, 0, 1, 1, 0, 0,        0, 1, 0, 16'h0,    16'h0);
        tbl[9]  = mk(1, 1, 6, 6, 0, 1, 0, 0,        1, 1, 1, 16'h0001, 16'h0001);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 6, 16'h00FF, 1, 1, 1, 16'h0001, 16'h0001);
        tbl[11] = mk(1, 1, 6, 6, 0, 1, 0, 0,        1, 0, 1, 16'h0001, 16'h0001);
        tbl[12] = mk(0, 1, 3, 5, 0, 1, 0, 0,        0, 1, 1, 16'h0,    16'h0);
        tbl[13] = mk(1, 0, 0, 0, 1, 1, 0, 0,        0, 1, 0, 16'h0,    16'h0);
        tbl[14] = mk(1, 1, 3, 5, 0, 1, 0, 0,        1, 1, 1, 16'h1234, 16'hBEEF);
        tbl[15] = mk(1, 0, 0, 0, 1, 1, 0, 0,        0, 1, 0, 16'h0,    16'h0);

        step(0, 1, 3, 5, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("reset_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_ready", {31'b0, rd_ready}, 32'd1);
        chk("reset_data", {rd_data_a, rd_data_b}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].acc,
                 tbl[i].wrn, tbl[i].wa, tbl[i].wd);
            chk($sformatf("v%0d_valid", i), {31'b0, rd_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("v%0d_ready", i), {31'b0, rd_ready}, {31'b0, tbl[i].er});
            if (tbl[i].cd)
                chk($sformatf("v%0d_data", i), {rd_data_a, rd_data_b}, {tbl[i].ea, tbl[i].eb});
        end

        // Continuous requests with a toggling consumer: exactly 20 in, 20 out, in order.
        for (int i = 0; i < NREG; i++) rf[i] = 16'($urandom);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_acc = 0;
        n_take = 0;
        for (int c = 0; c < 200 && !(n_acc == 20 && q.size() == 0); c++)
            step(1, n_acc < 20, 3'($urandom), 3'($urandom), (c % 2) == 0, 1, 0, 0);
        chk("stream_accepted", 32'(n_acc), 32'd20);
        chk("stream_taken", 32'(n_take), 32'd20);

        for (int c = 0; c < 400; c++)
            step(($urandom % 40) != 0, ($urandom % 3) != 0, 3'($urandom), 3'($urandom),
                 ($urandom % 2) == 0, ($urandom % 3) == 0, 3'($urandom), 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
